// File: rtl/mx_pkg.sv
// Shared definitions for the Manchester receiver: FSM state encoding and
// the framing bytes that bracket a frame's payload.
package mx_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    HUNT_SFD = 2'd1,
    RECEIVE  = 2'd2
  } state_t;

  localparam logic [7:0] PREAMBLE = 8'hAA;
  localparam logic [7:0] SFD      = 8'hD0;

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer for an asynchronous serial input, followed by a
// history flop used to flag rising, falling and any edges on the
// synchronized level.
module sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise,
  output logic fall,
  output logic any
);

  logic s1;
  logic s2;
  logic s3;

  // Synchronize din and keep one cycle of history; all flops idle high.
  always_ff @(posedge clk) begin
    if (!rst) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
      s3 <= 1'b1;
    end else begin
      s1 <= din;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise = s2 & ~s3;
  assign fall = ~s2 & s3;
  assign any  = s2 ^ s3;

endmodule

// File: rtl/mx_rcvr.sv
// Manchester receiver: recovers mid-bit transitions by timing edges against
// the nominal bit period, assembles bytes LSB-first, detects preamble and
// SFD, and reports bytes, carrier presence and end of frame.
module mx_rcvr
  import mx_pkg::*;
#(
  parameter int CLK_FREQ = 100_000_000,
  parameter int BIT_RATE = 50_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  output logic [7:0] data,
  output logic       valid,
  output logic       cardet,
  output logic       eof,
  output logic       error
);

  localparam int BITPD = CLK_FREQ / BIT_RATE;
  localparam int TW    = $clog2(2 * BITPD + 1);
  localparam logic [TW-1:0] TMAX = TW'(2 * BITPD);
  localparam logic [TW-1:0] TMID = TW'(3 * BITPD / 4);
  localparam logic [TW-1:0] TOUT = TW'(3 * BITPD / 2);

  state_t          state;
  logic [7:0]      sreg;
  logic [TW-1:0]   tcnt;
  logic [2:0]      bcnt;
  logic            fresh;
  logic            bit_done;
  logic            rise;
  logic            fall;
  logic            any;
  logic            mid_edge;
  logic            timeout;
  logic            dbit;

  sync_edge u_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (rxd),
    .rise (rise),
    .fall (fall),
    .any  (any)
  );

  // A line that has been quiet since the last timeout (fresh) has no phase
  // reference yet, so its first edge is taken as a mid-bit edge.
  assign mid_edge = any && (((state == IDLE) && fresh) || (tcnt >= TMID));
  assign timeout  = !mid_edge && (tcnt == TOUT);
  // Post-edge level low means the bit was 1; only meaningful on an edge.
  assign dbit     = fall ? 1'b1 : (rise ? 1'b0 : sreg[7]);
  assign cardet   = (state != IDLE);

  // Clocks since the last accepted mid-bit edge, saturating.
  always_ff @(posedge clk) begin
    if (!rst) begin
      tcnt <= '0;
    end else if (mid_edge) begin
      tcnt <= '0;
    end else if (tcnt != TMAX) begin
      tcnt <= tcnt + TW'(1);
    end
  end

  // Shift decoded bits in at the MSB; a timeout discards partial history.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sreg     <= '0;
      fresh    <= 1'b1;
      bit_done <= 1'b0;
    end else begin
      bit_done <= mid_edge;
      if (mid_edge) begin
        sreg  <= {dbit, sreg[7:1]};
        fresh <= 1'b0;
      end else if (timeout) begin
        sreg  <= '0;
        fresh <= 1'b1;
      end
    end
  end

  // Frame FSM: acts one cycle after each decoded bit so sreg is settled.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      bcnt  <= '0;
      data  <= '0;
      valid <= 1'b0;
      eof   <= 1'b0;
      error <= 1'b0;
    end else begin
      valid <= 1'b0;
      eof   <= 1'b0;
      error <= 1'b0;
      if (timeout && (state != IDLE)) begin
        eof   <= 1'b1;
        error <= (state == HUNT_SFD) || (bcnt != '0);
        state <= IDLE;
      end else if (bit_done) begin
        case (state)
          IDLE: begin
            if (sreg == PREAMBLE) state <= HUNT_SFD;
          end
          HUNT_SFD: begin
            if (sreg == SFD) begin
              state <= RECEIVE;
              bcnt  <= '0;
            end
          end
          RECEIVE: begin
            bcnt <= bcnt + 3'd1;
            if (bcnt == 3'd7) begin
              data  <= sreg;
              valid <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mx_rcvr.sv
// Directed bench for mx_rcvr with a 20-clock bit period. The line is held
// low before each frame so the first preamble bit begins with a clean
// mid-bit edge; afterwards it idles high.
module tb_mx_rcvr;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rxd = 1'b1;
  logic [7:0] data;
  logic       valid;
  logic       cardet;
  logic       eof;
  logic       error;

  int n_chk  = 0;
  int n_fail = 0;

  // monitor state
  logic [7:0] rx_q[$];
  int n_eof = 0;
  int n_err = 0;
  int n_err_alone = 0;
  int n_cd = 0;

  always #5 clk = ~clk;

  mx_rcvr #(.CLK_FREQ(100_000_000), .BIT_RATE(5_000_000)) dut (
    .clk    (clk),
    .rst    (rst),
    .rxd    (rxd),
    .data   (data),
    .valid  (valid),
    .cardet (cardet),
    .eof    (eof),
    .error  (error)
  );

  // Record output pulses away from the active edge.
  always @(negedge clk) begin
    if (valid) rx_q.push_back(data);
    if (eof) n_eof++;
    if (error) n_err++;
    if (error && !eof) n_err_alone++;
    if (cardet) n_cd++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic d, input int half);
    rxd = d;
    wait_cyc(half);
    rxd = ~d;
    wait_cyc(half);
  endtask

  task automatic send_byte(input logic [7:0] b, input int half);
    for (int i = 0; i < 8; i++) send_bit(b[i], half);
  endtask

  task automatic prep();
    rxd = 1'b0;
    wait_cyc(60);
  endtask

  int q0, e0, r0, c0;

  initial begin
    // reset state
    wait_cyc(5);
    check("rst_data", 32'(data), 32'h00);
    check("rst_valid", 32'(valid), 32'h0);
    check("rst_cardet", 32'(cardet), 32'h0);
    check("rst_eof", 32'(eof), 32'h0);
    check("rst_error", 32'(error), 32'h0);
    rst = 1'b1;
    wait_cyc(1);
    check("rel_pulses", 32'({valid, eof, error}), 32'h0);
    wait_cyc(20);

    // full frame, nominal rate
    q0 = rx_q.size(); e0 = n_eof; r0 = n_err;
    prep();
    send_byte(8'hAA, 10);
    check("A_cardet_after_pre", 32'(cardet), 32'h1);
    send_byte(8'hD0, 10);
    send_byte(8'h5A, 10);
    send_byte(8'h44, 10);
    send_byte(8'h30, 10);
    send_byte(8'h68, 10);
    send_byte(8'h69, 10);
    rxd = 1'b1;
    wait_cyc(15);
    check("A_eof_not_early", 32'(n_eof - e0), 32'd0);
    check("A_cardet_in_gap", 32'(cardet), 32'h1);
    wait_cyc(45);
    check("A_nbytes", 32'(rx_q.size() - q0), 32'd5);
    check("A_b0", 32'(rx_q[q0]), 32'h5A);
    check("A_b1", 32'(rx_q[q0+1]), 32'h44);
    check("A_b2", 32'(rx_q[q0+2]), 32'h30);
    check("A_b3", 32'(rx_q[q0+3]), 32'h68);
    check("A_b4", 32'(rx_q[q0+4]), 32'h69);
    check("A_eof", 32'(n_eof - e0), 32'd1);
    check("A_err", 32'(n_err - r0), 32'd0);
    check("A_cardet_end", 32'(cardet), 32'h0);
    check("A_data_hold", 32'(data), 32'h69);

    // partial trailing byte
    q0 = rx_q.size(); e0 = n_eof; r0 = n_err;
    prep();
    send_byte(8'hAA, 10);
    send_byte(8'hD0, 10);
    send_byte(8'h5A, 10);
    send_bit(1'b1, 10);
    send_bit(1'b0, 10);
    send_bit(1'b1, 10);
    rxd = 1'b1;
    wait_cyc(60);
    check("B_nbytes", 32'(rx_q.size() - q0), 32'd1);
    check("B_b0", 32'(rx_q[q0]), 32'h5A);
    check("B_eof", 32'(n_eof - e0), 32'd1);
    check("B_err", 32'(n_err - r0), 32'd1);

    // preamble only
    q0 = rx_q.size(); e0 = n_eof; r0 = n_err;
    prep();
    send_byte(8'hAA, 10);
    check("C_cardet_up", 32'(cardet), 32'h1);
    rxd = 1'b1;
    wait_cyc(60);
    check("C_cardet_down", 32'(cardet), 32'h0);
    check("C_nbytes", 32'(rx_q.size() - q0), 32'd0);
    check("C_eof", 32'(n_eof - e0), 32'd1);
    check("C_err", 32'(n_err - r0), 32'd1);

    // bit period skewed -10% and +10%
    for (int h = 9; h <= 11; h += 2) begin
      q0 = rx_q.size(); e0 = n_eof; r0 = n_err;
      prep();
      send_byte(8'hAA, h);
      send_byte(8'hD0, h);
      send_byte(8'h68, h);
      rxd = 1'b1;
      wait_cyc(60);
      check("D_nbytes", 32'(rx_q.size() - q0), 32'd1);
      check("D_b0", 32'(rx_q[q0]), 32'h68);
      check("D_eof", 32'(n_eof - e0), 32'd1);
      check("D_err", 32'(n_err - r0), 32'd0);
    end

    // reset in the middle of a byte
    q0 = rx_q.size(); e0 = n_eof; r0 = n_err;
    prep();
    send_byte(8'hAA, 10);
    send_byte(8'hD0, 10);
    send_byte(8'h5A, 10);
    send_bit(1'b0, 10);
    send_bit(1'b0, 10);
    send_bit(1'b1, 10);
    send_bit(1'b0, 10);
    rst = 1'b0;
    rxd = 1'b1;
    wait_cyc(1);
    check("E_data", 32'(data), 32'h00);
    check("E_cardet", 32'(cardet), 32'h0);
    check("E_pulses", 32'({valid, eof, error}), 32'h0);
    wait_cyc(3);
    rst = 1'b1;
    wait_cyc(60);
    check("E_nbytes", 32'(rx_q.size() - q0), 32'd1);
    check("E_eof", 32'(n_eof - e0), 32'd0);
    check("E_err", 32'(n_err - r0), 32'd0);
    q0 = rx_q.size(); e0 = n_eof; r0 = n_err;
    prep();
    send_byte(8'hAA, 10);
    send_byte(8'hD0, 10);
    send_byte(8'h44, 10);
    send_byte(8'h30, 10);
    rxd = 1'b1;
    wait_cyc(60);
    check("E2_nbytes", 32'(rx_q.size() - q0), 32'd2);
    check("E2_b0", 32'(rx_q[q0]), 32'h44);
    check("E2_b1", 32'(rx_q[q0+1]), 32'h30);
    check("E2_eof", 32'(n_eof - e0), 32'd1);
    check("E2_err", 32'(n_err - r0), 32'd0);

    // noise without preamble
    q0 = rx_q.size(); e0 = n_eof; r0 = n_err; c0 = n_cd;
    prep();
    send_byte(8'h55, 10);
    rxd = 1'b1;
    wait_cyc(60);
    check("F_cardet", 32'(n_cd - c0), 32'd0);
    check("F_nbytes", 32'(rx_q.size() - q0), 32'd0);
    check("F_eof", 32'(n_eof - e0), 32'd0);
    check("F_err", 32'(n_err - r0), 32'd0);

    check("err_without_eof", 32'(n_err_alone), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mx_rcvr.md
MX_RCVR -- requirements
Module: mx_rcvr

Interface
REQ-001 Parameter CLK_FREQ, default 100_000_000, system clock frequency in Hz.
REQ-002 Parameter BIT_RATE, default 50_000, Manchester bit rate in bits/s; BITPD = CLK_FREQ/BIT_RATE clocks (2000 at defaults).
REQ-003 clk  input  1  single system clock; all logic on rising edge.
REQ-004 rst  input  1  synchronous, active-low reset.
REQ-005 rxd  input  1  asynchronous Manchester serial input; bit d sent as level d for the first half-bit, then !d for the second half-bit, LSB first.
REQ-006 data  output  8  last completed received byte.
REQ-007 valid  output  1  one-cycle pulse; data holds a new byte.
REQ-008 cardet  output  1  carrier detected: high from preamble match until end of frame.
REQ-009 eof  output  1  one-cycle pulse at end of frame.
REQ-010 error  output  1  one-cycle pulse, coincident with eof, when the frame ends with a partial byte or the SFD is never seen.

Function
REQ-011 rxd shall pass a 2-flop synchronizer; edge detection shall act on the synchronized signal (2-clock input latency).
REQ-012 A free-running counter tcnt shall count clocks since the last accepted mid-bit edge, saturating at 2*BITPD.
REQ-013 An edge with tcnt >= 3*BITPD/4 shall be a mid-bit edge: decoded bit = inverse of the post-edge level; tcnt clears to 0.
REQ-014 An edge with tcnt < 3*BITPD/4 shall be a bit-boundary edge and be ignored.
REQ-015 In IDLE, the first edge of any kind shall be accepted as a mid-bit edge.
REQ-016 Each decoded bit shall shift into an 8-bit register sreg at the MSB (right shift), so sreg holds the last 8 bits LSB-first.
REQ-017 States: IDLE, HUNT_SFD, RECEIVE.
REQ-018 IDLE -> HUNT_SFD when sreg == 8'hAA after a decoded bit; cardet rises the next cycle.
REQ-019 HUNT_SFD -> RECEIVE when sreg == 8'hD0 after a decoded bit; 3-bit bit counter cleared.
REQ-020 In RECEIVE, after the 8th bit of each byte, data <= sreg and valid pulses the following cycle; bit counter wraps 7 -> 0.
REQ-021 Timeout: tcnt reaching 3*BITPD/2 in HUNT_SFD or RECEIVE shall end the frame: eof pulses, cardet falls, state -> IDLE, sreg cleared.
REQ-022 error shall pulse with eof if the timeout occurs in HUNT_SFD, or in RECEIVE with bit counter != 0.
REQ-023 Timeout in IDLE shall clear sreg only; no eof, no error.
REQ-024 A mid-bit edge and timeout in the same cycle: the edge wins; no timeout.
REQ-025 data shall hold its value until the next valid; valid, eof and error never assert in the same cycle as reset release.

Reset
REQ-026 While rst == 0 at a clock edge: state IDLE, sreg 0, tcnt 0, bit counter 0, synchronizer flops 1, data 8'h00, valid/cardet/eof/error 0.
REQ-027 Reset mid-frame shall abort silently: no eof, no error, no valid.

Structure
REQ-028 Shared package mx_pkg shall hold the state enum, PREAMBLE = 8'hAA and SFD = 8'hD0 constants.
REQ-029 One sub-module, sync_edge, shall implement the 2-flop synchronizer plus rise/fall/any-edge detection.
REQ-030 Counter widths shall be derived via $clog2 from 2*BITPD.

Verification
REQ-031 Bytes AA, D0, 5A, 44, 30, 68, 69 at 50 kbps, then idle-high -> cardet high after AA; valid pulses with 5A,44,30,68,69; eof ~30 us after last bit, error 0.
REQ-032 AA, D0, 5A, then 3 extra bits then idle -> valid with 5A; eof and error pulse together.
REQ-033 AA, then idle -> cardet high then low; eof and error pulse; no valid.
REQ-034 AA, D0, 68 with bit period skewed +/-10% -> valid with 68, error 0.
REQ-035 rst driven low midway through byte 44 of REQ-031 frame -> all outputs 0 next cycle, no eof/error; subsequent fresh frame received correctly.
REQ-036 Noise byte 55 (no AA) then idle -> cardet stays 0, no valid, eof or error.
